// File: rtl/uart_tx_sched.sv
// Byte FIFO feeding a UART transmitter: pops one byte at a time, strobes the UART,
// and waits for its completion pulse, with a watchdog that abandons a silent transfer.
module uart_tx_sched #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     tx_timeout,
    output logic                     busy,
    output logic [7:0]               uart_txd_data,
    output logic                     uart_transmit,
    input  logic                     uart_txd_done,
    output logic [1:0]               fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [15:0]     wd;
    logic [15:0]     wd_next;
    logic [16:0]     wd_inc;
    logic            timeout_hit;
    logic            push;
    logic            drop;
    logic            pop;

    // flush outranks a same-edge push, so that push is neither stored nor counted as dropped
    assign push  = wr_en && !flush && !full;
    assign drop  = wr_en && !flush && full;
    assign pop   = (state == IDLE) && !empty && !flush;

    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign busy          = (state != IDLE);
    assign uart_transmit = (state == START);
    assign fsm_state     = state;
    assign wd_inc        = {1'b0, wd} + 17'd1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            tx_timeout <= 1'b0;
        end else if (flush) begin
            overflow   <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (timeout_hit) begin
                tx_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wd            <= '0;
            uart_txd_data <= 8'h00;
        end else begin
            state <= state_next;
            wd    <= wd_next;
            if (pop) begin
                uart_txd_data <= mem[rd_ptr];
            end
        end
    end

    // Done is only meaningful in WAIT; the watchdog trips on the cycle it would reach TIMEOUT
    always_comb begin
        state_next  = state;
        wd_next     = wd;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = START;
                end
            end
            START: begin
                wd_next    = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (uart_txd_done) begin
                    state_next = IDLE;
                end else begin
                    wd_next = wd_inc[15:0];
                    if (wd_inc == 17'(TIMEOUT)) begin
                        timeout_hit = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: strobed bytes are checked against a queue of
// expected bytes filled as pushes are driven; timing is checked with cycle stamps.
module tb_uart_tx_sched;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        flush;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic        tx_timeout;
    logic        busy;
    logic [7:0]  uart_txd_data;
    logic        uart_transmit;
    logic        uart_txd_done;
    logic [1:0]  fsm_state;

    uart_tx_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .flush         (flush),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .tx_timeout    (tx_timeout),
        .busy          (busy),
        .uart_txd_data (uart_txd_data),
        .uart_transmit (uart_transmit),
        .uart_txd_done (uart_txd_done),
        .fsm_state     (fsm_state)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          strobe_cnt = 0;
    int          strobe_cyc = 0;
    int          done_cyc = 0;
    int          p;
    int          s;
    int          base;
    logic        prev_tx = 1'b0;
    logic [7:0]  exp_q[$];

    // clock / cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: observed=sim_time_exceeded expected=finish");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every strobe must match the oldest expected byte
    always @(negedge clk) begin
        if (!rst) begin
            if (uart_transmit) begin
                strobe_cnt++;
                strobe_cyc = cyc;
                check("strobe_one_cycle", prev_tx, 1'b0);
                check("strobe_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("strobe_data", uart_txd_data, exp_q.pop_front());
            end
            prev_tx = uart_transmit;
        end else begin
            prev_tx = 1'b0;
        end
    end

    // driver tasks
    task automatic at_pos;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        at_pos;
        wr_en = 1'b0;
    endtask

    task automatic pulse_done;
        uart_txd_done = 1'b1;
        at_pos;
        uart_txd_done = 1'b0;
        done_cyc = cyc;
    endtask

    task automatic wait_strobe(input int n);
        int k = 0;
        while (strobe_cnt < n && k < 60) begin
            at_neg;
            k++;
        end
        check("strobe_arrival", strobe_cnt >= n, 1'b1);
    endtask

    task automatic wait_cyc(input int target);
        int k = 0;
        while (cyc < target && k < 100) begin
            at_neg;
            k++;
        end
        check("cycle_reached", cyc, target);
    endtask

    task automatic check_reset_values;
        check("rst_count", count, 4'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_tx_timeout", tx_timeout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_transmit", uart_transmit, 1'b0);
        check("rst_data", uart_txd_data, 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        flush = 1'b0;
        uart_txd_done = 1'b0;
        repeat (3) at_neg;
        check_reset_values();
        at_pos;
        rst = 1'b0;

        // single byte: strobe in the 2nd cycle after the push edge
        push(8'h41, 1'b1);
        p = cyc;
        at_neg;
        check("lat_count_after_push", count, 4'd1);
        check("lat_no_early_strobe", uart_transmit, 1'b0);
        check("lat_idle_busy", busy, 1'b0);
        at_neg;
        check("lat_strobe", uart_transmit, 1'b1);
        check("lat_data", uart_txd_data, 8'h41);
        check("lat_busy_start", busy, 1'b1);
        check("lat_count_popped", count, 4'd0);
        check("lat_strobe_cycle", strobe_cyc, p + 1);
        at_neg;
        check("wait_no_strobe", uart_transmit, 1'b0);
        check("wait_busy", busy, 1'b1);
        check("wait_state", fsm_state, 2'd2);
        pulse_done();
        at_neg;
        check("done_idle_busy", busy, 1'b0);
        check("data_held", uart_txd_data, 8'h41);

        // overflow: 9 accepted, 10th dropped
        base = strobe_cnt;
        for (int i = 0; i < 10; i++) push(8'(i), i < 9);
        at_neg;
        check("ovf_count", count, 4'd8);
        check("ovf_full", full, 1'b1);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_first_popped", strobe_cnt, base + 1);
        for (int i = 1; i <= 8; i++) begin
            pulse_done();
            wait_strobe(base + 1 + i);
            check("drain_gap", strobe_cyc - done_cyc, 1);
            at_neg;
        end
        pulse_done();
        at_neg;
        check("drain_empty", empty, 1'b1);
        check("drain_busy", busy, 1'b0);
        check("ovf_sticky", overflow, 1'b1);
        check("drain_queue", exp_q.size(), 0);
        flush = 1'b1;
        at_pos;
        flush = 1'b0;
        at_neg;
        check("flush_clears_ovf", overflow, 1'b0);

        // three bytes, done 5 cycles after each strobe
        base = strobe_cnt;
        push(8'hA0, 1'b1);
        push(8'hA1, 1'b1);
        push(8'hA2, 1'b1);
        for (int j = 0; j < 3; j++) begin
            wait_strobe(base + 1 + j);
            if (j > 0) check("seq_gap", strobe_cyc - done_cyc, 1);
            s = strobe_cyc;
            at_pos;
            while (cyc < s + 4) at_pos;
            pulse_done();
        end
        at_neg;
        at_neg;
        check("seq_total", strobe_cnt, base + 3);
        check("seq_idle", busy, 1'b0);

        // watchdog: no done, timeout after 16 WAIT cycles
        base = strobe_cnt;
        push(8'hB0, 1'b1);
        push(8'hB1, 1'b1);
        wait_strobe(base + 1);
        s = strobe_cyc;
        wait_cyc(s + 16);
        check("to_not_yet", tx_timeout, 1'b0);
        check("to_still_busy", busy, 1'b1);
        at_neg;
        check("to_flag", tx_timeout, 1'b1);
        check("to_back_idle", busy, 1'b0);
        check("to_count", count, 4'd1);
        wait_strobe(base + 2);
        check("to_next_strobe", strobe_cyc, s + 18);
        at_neg;
        pulse_done();
        at_neg;
        check("to_sticky", tx_timeout, 1'b1);

        // flush with push while a byte is in flight
        base = strobe_cnt;
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b1);
        at_neg;
        check("fl_count_before", count, 4'd4);
        check("fl_busy_before", busy, 1'b1);
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hEE;
        at_pos;
        flush = 1'b0;
        wr_en = 1'b0;
        exp_q.delete();
        at_neg;
        check("fl_count", count, 4'd0);
        check("fl_empty", empty, 1'b1);
        check("fl_overflow", overflow, 1'b0);
        check("fl_timeout_cleared", tx_timeout, 1'b0);
        check("fl_inflight_busy", busy, 1'b1);
        pulse_done();
        repeat (8) at_neg;
        check("fl_no_more_strobes", strobe_cnt, base + 1);
        check("fl_idle", busy, 1'b0);

        // asynchronous reset during WAIT with 3 queued
        base = strobe_cnt;
        for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i), 1'b1);
        at_neg;
        check("rw_count_before", count, 4'd3);
        check("rw_busy_before", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        exp_q.delete();
        at_pos;
        at_pos;
        rst = 1'b0;
        pulse_done();
        repeat (10) at_neg;
        check("rw_no_strobe", strobe_cnt, base + 1);
        check("rw_idle", busy, 1'b0);
        check("rw_empty", empty, 1'b1);
        check("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, TX FIFO depth in bytes (power of 2, 2..64).
REQ-002 SHALL have parameter TIMEOUT, default 65535, max cycles to wait for uart_txd_done (1..65535).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset: asynchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  push request, sampled each clk.
REQ-006 SHALL have port wr_data  input  8  byte to push.
REQ-007 SHALL have port flush  input  1  discard queued bytes and clear sticky flags.
REQ-008 SHALL have port full  output  1  high when count == DEPTH.
REQ-009 SHALL have port empty  output  1  high when count == 0.
REQ-010 SHALL have port count  output  clog2(DEPTH)+1  bytes queued, excluding the in-flight byte.
REQ-011 SHALL have port overflow  output  1  sticky; a push was dropped.
REQ-012 SHALL have port tx_timeout  output  1  sticky; a byte timed out waiting for done.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-014 SHALL have port uart_txd_data  output  8  byte presented to the UART transmitter.
REQ-015 SHALL have port uart_transmit  output  1  one-cycle start strobe to the UART.
REQ-016 SHALL have port uart_txd_done  input  1  UART completion pulse.

Function
REQ-017 SHALL accept a push on each edge where wr_en=1, flush=0 and full=1 is not asserted at that edge; count increments the following cycle.
REQ-018 SHALL drop a push when full=1, and SHALL set overflow, even if a pop occurs on the same edge.
REQ-019 SHALL leave count unchanged on an edge with both an accepted push and a pop.
REQ-020 SHALL implement FSM states IDLE, START and WAIT, all registered.
REQ-021 IDLE: if empty=0, SHALL pop the head byte into uart_txd_data and go to START; otherwise SHALL stay in IDLE.
REQ-022 START: SHALL drive uart_transmit=1 for exactly this one cycle, SHALL clear the watchdog, and SHALL go to WAIT.
REQ-023 WAIT: on uart_txd_done=1 SHALL go to IDLE; otherwise SHALL increment the watchdog, and when the watchdog reaches TIMEOUT SHALL set tx_timeout and go to IDLE.
REQ-024 SHALL hold uart_txd_data stable from the pop edge until the next pop.
REQ-025 SHALL ignore uart_txd_done in IDLE and START.
REQ-026 Latency: a byte pushed into an empty FIFO with the FSM in IDLE SHALL produce uart_transmit=1 in the 2nd cycle after the push edge; back-to-back bytes SHALL be separated by 2 cycles after the done pulse (done edge -> IDLE, pop -> START).
REQ-027 flush=1 SHALL on that edge zero count, reset the FIFO pointers, clear overflow and tx_timeout, and drop any same-cycle push without setting overflow.
REQ-028 flush=1 SHALL NOT abort an in-flight byte: START and WAIT proceed normally, and a flush while in IDLE SHALL prevent a pop on that edge.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH, and count SHALL saturate at DEPTH and never underflow.

Reset
REQ-030 rst=1 SHALL immediately force: FSM to IDLE, count=0, pointers=0, empty=1, full=0, overflow=0, tx_timeout=0, busy=0, uart_transmit=0, uart_txd_data=8'h00, watchdog=0.
REQ-031 rst asserted mid-transfer SHALL abandon the in-flight byte and all queued bytes, with no uart_transmit strobe after release until a new push.

Verification
REQ-032 Push 8'h41 into an idle, empty block -> uart_transmit=1 for one cycle, 2 cycles after the push edge, with uart_txd_data=8'h41; busy=1 until the cycle after done.
REQ-033 Push 9 bytes 8'h00..8'h08 with done held low -> the first byte is popped, count reaches 8, full=1, and overflow=1 on the 10th push attempt; the dropped byte never appears.
REQ-034 Queue 8'hA0,8'hA1,8'hA2 and pulse done 5 cycles after each strobe -> strobes in order A0, A1, A2, each 2 cycles after the preceding done.
REQ-035 TIMEOUT=16, push one byte, never pulse done -> tx_timeout=1 after 16 WAIT cycles, then the FSM returns to IDLE and the next byte is strobed.
REQ-036 With 4 queued bytes in WAIT, pulse flush with wr_en=1 -> count=0, overflow=0, the in-flight byte completes on done, and no further strobes occur.
REQ-037 Assert rst during WAIT with 3 queued bytes -> all outputs take REQ-030 values, and a later done pulse produces no activity.
